// File: rtl/hand_reader.sv
// Reads one blackjack hand from parallel card slots, streams the cards out over a
// valid/ready port and scores them. Scoring is built only when HAND_READER_SCORE_EN is defined.
module hand_reader (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] count_i,
  input  logic [7:0] slot_0_i,
  input  logic [7:0] slot_1_i,
  input  logic [7:0] slot_2_i,
  input  logic [7:0] slot_3_i,
  input  logic [7:0] slot_4_i,
  input  logic [7:0] slot_5_i,
  input  logic [7:0] slot_6_i,
  input  logic [7:0] slot_7_i,
  input  logic [7:0] slot_8_i,
  input  logic [7:0] slot_9_i,
  input  logic [7:0] slot_10_i,
  input  logic       card_ready_i,
  output logic [7:0] card_o,
  output logic       card_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [6:0] total_o,
  output logic       soft_o,
  output logic       bust_o,
  output logic       err_o
);
  localparam int SLOTS = 11;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, FINISH = 2'd2} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] slot_in [SLOTS];
  logic [7:0] snap [SLOTS];
  logic [3:0] cnt;
  logic [3:0] idx;
  logic [3:0] cnt_clamp;
  logic       accept;
  logic       xfer;
  logic       last;

  always_comb begin
    slot_in[0]  = slot_0_i;
    slot_in[1]  = slot_1_i;
    slot_in[2]  = slot_2_i;
    slot_in[3]  = slot_3_i;
    slot_in[4]  = slot_4_i;
    slot_in[5]  = slot_5_i;
    slot_in[6]  = slot_6_i;
    slot_in[7]  = slot_7_i;
    slot_in[8]  = slot_8_i;
    slot_in[9]  = slot_9_i;
    slot_in[10] = slot_10_i;
  end

  assign cnt_clamp = (count_i > 4'd11) ? 4'd11 : count_i;
  assign accept    = (state == IDLE) && start_i;
  assign xfer      = (state == SEND) && card_ready_i;
  assign last      = (idx == cnt - 4'd1);

  always_comb begin
    state_nxt    = state;
    card_valid_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_nxt = (cnt_clamp == 4'd0) ? FINISH : SEND;
      end
      SEND: begin
        card_valid_o = 1'b1;
        if (xfer && last) state_nxt = FINISH;
      end
      FINISH: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // card_o always holds snap[idx]; it only advances on a transfer, so it is stable under backpressure
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx    <= 4'd0;
      card_o <= 8'd0;
      for (int i = 0; i < SLOTS; i++) snap[i] <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        for (int i = 0; i < SLOTS; i++) snap[i] <= slot_in[i];
        cnt    <= cnt_clamp;
        idx    <= 4'd0;
        card_o <= slot_in[0];
      end else if (xfer && !last) begin
        idx    <= idx + 4'd1;
        card_o <= snap[idx + 4'd1];
      end
    end
  end

`ifdef HAND_READER_SCORE_EN
  logic [6:0] raw;
  logic       ace;
  logic [6:0] raw_sum;
  logic       ace_sum;
  logic [7:0] fin;

  function automatic logic [3:0] card_value(input logic [7:0] code);
    if (code == 8'd1) return 4'd1;
    else if (code >= 8'd2 && code <= 8'd10) return code[3:0];
    else if (code >= 8'd11 && code <= 8'd13) return 4'd10;
    else return 4'd0;
  endfunction

  function automatic logic card_invalid(input logic [7:0] code);
    return (code == 8'd0) || (code > 8'd13);
  endfunction

  // Returns {soft, total}: one ace is promoted to 11 only when that keeps the hand at 21 or less
  function automatic logic [7:0] final_score(input logic [6:0] sum, input logic has_ace);
    logic [6:0] boosted;
    boosted = sum + 7'd10;
    if (has_ace && boosted <= 7'd21) return {1'b1, boosted};
    return {1'b0, sum};
  endfunction

  assign raw_sum = raw + {3'b000, card_value(card_o)};
  assign ace_sum = ace | (card_o == 8'd1);
  assign fin     = final_score(raw_sum, ace_sum);

  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      raw     <= 7'd0;
      ace     <= 1'b0;
      total_o <= 7'd0;
      soft_o  <= 1'b0;
      bust_o  <= 1'b0;
      err_o   <= 1'b0;
    end else if (xfer) begin
      raw   <= raw_sum;
      ace   <= ace_sum;
      err_o <= err_o | card_invalid(card_o);
      if (last) begin
        total_o <= fin[6:0];
        soft_o  <= fin[7];
        bust_o  <= (fin[6:0] > 7'd21);
      end
    end
  end
`else
  assign total_o = 7'd0;
  assign soft_o  = 1'b0;
  assign bust_o  = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule
